// File: rtl/acp_pkg.sv
// Shared AXI3 constants and FSM state encoding for the ACP burst reader.
package acp_pkg;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [2:0] SIZE_8B     = 3'b011;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam int unsigned BOUNDARY_4K = 4096;
   // 8-byte beats that fit into one 4 KB page
   localparam int unsigned BEATS_PER_4K = BOUNDARY_4K / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } acp_state_t;

endpackage

// File: rtl/acp_burst_len.sv
// Burst length picker: min(remaining beats, MAX_BURST, beats left in the 4 KB page).
module acp_burst_len
   import acp_pkg::*;
#(
   parameter int MAX_BURST = 16,
   parameter int CNT_W     = 16
) (
   input  logic [8:0]       addr_beat,   // address bits [11:3]: beat offset inside the page
   input  logic [CNT_W-1:0] remaining,
   output logic [4:0]       len
);

   logic [9:0] beats_left;
   logic [4:0] cap;

   // Combinational three-way minimum; result is 1..MAX_BURST whenever remaining > 0
   always_comb begin
      beats_left = 10'(BEATS_PER_4K) - {1'b0, addr_beat};
      if (remaining > CNT_W'(MAX_BURST)) cap = 5'(MAX_BURST);
      else                               cap = remaining[4:0];
      if ({5'd0, cap} > beats_left) len = beats_left[4:0];
      else                          len = cap;
   end

endmodule

// File: rtl/acp_burst_reader.sv
// AXI3 read master for the Zynq S_AXI_ACP port: splits a (address, beat count)
// command into page-safe INCR bursts and streams the read data out unbuffered.
//
// Handshakes: every valid/ready pair transfers exactly one item on a rising clk
// edge where both are high; a valid, once raised, stays high with its payload
// stable until that edge (arvalid/araddr/arlen here, cmd_* and r* upstream).
module acp_burst_reader
   import acp_pkg::*;
#(
   parameter int         DATA_W      = 64,
   parameter int         MAX_BURST   = 16,
   parameter int         CNT_W       = 16,
   parameter logic [2:0] ARID_VAL    = 3'd0,
   parameter logic [3:0] ARCACHE_VAL = 4'b1111,
   parameter logic [4:0] ARUSER_VAL  = 5'b00001
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [31:0]       cmd_addr,
   input  logic [CNT_W-1:0]  cmd_beats,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        dbg_state,
   output logic [31:0]       S_AXI_ACP_0_araddr,
   output logic [1:0]        S_AXI_ACP_0_arburst,
   output logic [3:0]        S_AXI_ACP_0_arcache,
   output logic [2:0]        S_AXI_ACP_0_arid,
   output logic [3:0]        S_AXI_ACP_0_arlen,
   output logic [1:0]        S_AXI_ACP_0_arlock,
   output logic [2:0]        S_AXI_ACP_0_arprot,
   output logic [3:0]        S_AXI_ACP_0_arqos,
   output logic [2:0]        S_AXI_ACP_0_arsize,
   output logic [4:0]        S_AXI_ACP_0_aruser,
   output logic              S_AXI_ACP_0_arvalid,
   input  logic              S_AXI_ACP_0_arready,
   input  logic [DATA_W-1:0] S_AXI_ACP_0_rdata,
   input  logic [2:0]        S_AXI_ACP_0_rid,
   input  logic              S_AXI_ACP_0_rlast,
   input  logic [1:0]        S_AXI_ACP_0_rresp,
   input  logic              S_AXI_ACP_0_rvalid,
   output logic              S_AXI_ACP_0_rready
);

   acp_state_t       state, state_n;
   logic [31:0]      addr_q;
   logic [CNT_W-1:0] rem_q;
   logic [3:0]       arlen_q;
   logic [4:0]       burst_left;
   logic             err_q;

   logic [4:0]       cur_len;
   logic [31:0]      addr_next;
   logic [31:0]      addr_in;
   logic [CNT_W-1:0] rem_in;
   logic [4:0]       len_n;
   logic             r_hs;
   logic             last_of_burst;
   logic             beat_bad;

   // Address/count that the next burst starts from: the command itself when idle,
   // otherwise the position just past the current beat/burst.
   assign cur_len       = {1'b0, arlen_q} + 5'd1;
   assign addr_next     = addr_q + {24'd0, cur_len, 3'b000};
   assign addr_in       = (state == ST_IDLE) ? (cmd_addr & 32'hFFFF_FFF8) : addr_next;
   assign rem_in        = (state == ST_IDLE) ? cmd_beats : rem_q - CNT_W'(1);
   assign r_hs          = (state == ST_DATA) && S_AXI_ACP_0_rvalid && m_ready;
   assign last_of_burst = (burst_left == 5'd1);
   // A foreign rid cannot be ours (single id, one burst in flight), so it is
   // treated like any other malformed beat.
   assign beat_bad      = (S_AXI_ACP_0_rresp != RESP_OKAY) ||
                          (S_AXI_ACP_0_rlast != last_of_burst) ||
                          (S_AXI_ACP_0_rid != ARID_VAL);

   acp_burst_len #(
      .MAX_BURST (MAX_BURST),
      .CNT_W     (CNT_W)
   ) u_len (
      .addr_beat (addr_in[11:3]),
      .remaining (rem_in),
      .len       (len_n)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (cmd_valid) state_n = (cmd_beats == '0) ? ST_DONE : ST_ADDR;
         ST_ADDR: if (S_AXI_ACP_0_arready) state_n = ST_DATA;
         ST_DATA: if (r_hs && last_of_burst) state_n = (rem_in != '0) ? ST_ADDR : ST_DONE;
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Datapath: address, counters, registered arlen and sticky error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q     <= '0;
         rem_q      <= '0;
         arlen_q    <= '0;
         burst_left <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= addr_in;
                  rem_q   <= rem_in;
                  arlen_q <= 4'(len_n - 5'd1);
                  err_q   <= 1'b0;
               end
            end
            ST_ADDR: begin
               if (S_AXI_ACP_0_arready) burst_left <= cur_len;
            end
            ST_DATA: begin
               if (r_hs) begin
                  rem_q      <= rem_in;
                  burst_left <= burst_left - 5'd1;
                  if (beat_bad) err_q <= 1'b1;
                  if (last_of_burst) begin
                     addr_q  <= addr_in;
                     arlen_q <= 4'(len_n - 5'd1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; R channel is a straight pass-through in DATA
   always_comb begin
      cmd_ready           = (state == ST_IDLE);
      busy                = (state != ST_IDLE);
      done                = (state == ST_DONE);
      err                 = err_q;
      dbg_state           = state;
      m_data              = S_AXI_ACP_0_rdata;
      m_valid             = (state == ST_DATA) && S_AXI_ACP_0_rvalid;
      m_last              = (state == ST_DATA) && S_AXI_ACP_0_rvalid && (rem_q == CNT_W'(1));
      S_AXI_ACP_0_rready  = (state == ST_DATA) && m_ready;
      S_AXI_ACP_0_arvalid = (state == ST_ADDR);
      S_AXI_ACP_0_araddr  = addr_q;
      S_AXI_ACP_0_arlen   = arlen_q;
      S_AXI_ACP_0_arburst = BURST_INCR;
      S_AXI_ACP_0_arsize  = SIZE_8B;
      S_AXI_ACP_0_arcache = ARCACHE_VAL;
      S_AXI_ACP_0_aruser  = ARUSER_VAL;
      S_AXI_ACP_0_arid    = ARID_VAL;
      S_AXI_ACP_0_arlock  = 2'b00;
      S_AXI_ACP_0_arprot  = 3'b000;
      S_AXI_ACP_0_arqos   = 4'b0000;
   end

endmodule
